direction_normalize: RTL

DIRECTION_NORMALIZE -- requirements
Module: direction_normalize

---
 rtl/direction_normalize_pkg.sv | 44 ++++
 rtl/fx_seq_divider.sv | 91 +++++++++
 rtl/direction_normalize.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/direction_normalize_pkg.sv
// direction_normalize_pkg
//   Shared ray-direction types used by the normalisation pipeline, plus the
//   latency constants of the square-root and divider stages.
//   Word width and fraction width come from the WIDTH / Q_BITS macros, which
//   default to 32 / 16 when the build does not set them.
//   Types:
//     RayDirection     - x/y/z signed Q-format components
//     RayDirection_sqr - x/y/z plus their unsigned Q-format squares
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

package direction_normalize_pkg;

  typedef struct packed {
    logic [`WIDTH-1:0] x;
    logic [`WIDTH-1:0] y;
    logic [`WIDTH-1:0] z;
  } RayDirection;

  typedef struct packed {
    logic [`WIDTH-1:0] x;
    logic [`WIDTH-1:0] y;
    logic [`WIDTH-1:0] z;
    logic [`WIDTH-1:0] sqr_x;
    logic [`WIDTH-1:0] sqr_y;
    logic [`WIDTH-1:0] sqr_z;
  } RayDirection_sqr;

  // Root bits produced by the bit-serial square root of (S << q_bits),
  // where S is width+2 bits wide: ceil((width + 2 + q_bits) / 2).
  function automatic int unsigned n_sqrt(input int unsigned width, input int unsigned q_bits);
    return (width + q_bits + 3) / 2;
  endfunction

  // Quotient bits produced for one component: |c| << q_bits is width+q_bits wide.
  function automatic int unsigned n_div(input int unsigned width, input int unsigned q_bits);
    return width + q_bits;
  endfunction

endpackage

// File: rtl/fx_seq_divider.sv
// fx_seq_divider
//   Restoring unsigned divider, one quotient bit per clock.
//   The first bit is computed on the same edge that samples start_i, so a
//   DividendW-bit quotient is complete DividendW edges after start and done_o
//   is high for the following cycle with quotient_o valid. Division by zero
//   yields an all-ones quotient.
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     start_i     - load operands and begin (restarts if already busy)
//     dividend_i  - unsigned dividend
//     divisor_i   - unsigned divisor
//     busy_o      - iterations still pending after the start edge
//     done_o      - one-cycle pulse, quotient_o holds the result
//     quotient_o  - floored quotient
module fx_seq_divider #(
  parameter int unsigned DividendW = 48,
  parameter int unsigned DivisorW  = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DividendW-1:0] dividend_i,
  input  logic [DivisorW-1:0]  divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DividendW-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(DividendW);

  // quo_q shifts dividend bits out of the top and quotient bits in at the bottom.
  logic [DividendW-1:0] quo_q, quo_d, quo_cur;
  logic [DivisorW-1:0]  rem_q, rem_d, rem_cur;
  logic [DivisorW-1:0]  dvs_q, dvs_d, dvs_cur;
  logic [DivisorW:0]    rem_sh;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_cur;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 q_bit;

  always_comb begin
    quo_cur = start_i ? dividend_i : quo_q;
    rem_cur = start_i ? '0 : rem_q;
    dvs_cur = start_i ? divisor_i : dvs_q;
    cnt_cur = start_i ? '0 : cnt_q;
    rem_sh  = {rem_cur, quo_cur[DividendW-1]};
    q_bit   = (rem_sh >= {1'b0, dvs_cur});

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i || busy_q) begin
      quo_d  = {quo_cur[DividendW-2:0], q_bit};
      // Remainder stays below the divisor, so the low bits carry the exact difference.
      rem_d  = q_bit ? (rem_sh[DivisorW-1:0] - dvs_cur) : rem_sh[DivisorW-1:0];
      dvs_d  = dvs_cur;
      cnt_d  = cnt_cur + CntW'(1);
      busy_d = 1'b1;
      if (cnt_cur == CntW'(DividendW - 1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/direction_normalize.sv
// direction_normalize
//   Normalises a ray direction to unit length in Q-format:
//   S = x^2+y^2+z^2 (from the supplied squares), M = floor(sqrt(S << Q_BITS)),
//   c_out = sign(c) * min(floor((|c| << Q_BITS) / M), 1.0).
//   Square root runs inline (one root bit per cycle); the three divisions share
//   one fx_seq_divider. Latency 2 + N_SQRT + 3*N_DIV edges from acceptance.
//   Optional build macro DIRECTION_NORMALIZE_ZERO_CHECK_EN: a zero vector
//   (S == 0) skips straight to DONE and reports zero_err; otherwise zero_err
//   is tied low and a zero divisor saturates each component to 1.0.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     start     - RDS_in valid
//     RDS_in    - components and their squares
//     ready     - idle, a vector is accepted this cycle
//     valid_out - one-cycle pulse, RD_out holds a new result
//     RD_out    - normalised direction, held until the next result or reset
//     overrun   - one-cycle pulse after start was seen while busy
//     zero_err  - pulses with valid_out for a zero vector
module direction_normalize
  import direction_normalize_pkg::*;
#(
  parameter int unsigned WIDTH  = `WIDTH,
  parameter int unsigned Q_BITS = `Q_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  RayDirection_sqr RDS_in,
  output logic            ready,
  output logic            valid_out,
  output RayDirection     RD_out,
  output logic            overrun,
  output logic            zero_err
);

  localparam int unsigned NSqrt = n_sqrt(WIDTH, Q_BITS);
  localparam int unsigned NDiv  = n_div(WIDTH, Q_BITS);
  localparam int unsigned SumW  = WIDTH + 2;
  localparam int unsigned RadW  = 2 * NSqrt;
  localparam int unsigned CntW  = $clog2(NDiv);
  localparam logic [WIDTH-1:0] One = WIDTH'(1) << Q_BITS;

  typedef enum logic [2:0] {
    StIdle, StSum, StSqrt, StDivX, StDivY, StDivZ, StDone
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  RayDirection_sqr    rds_q;
  logic [RadW-1:0]    sq_rad_q;
  logic [NSqrt:0]     sq_rem_q;
  logic [NSqrt-1:0]   sq_root_q;
  logic [WIDTH-1:0]   res_x_q, res_y_q;
`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
  logic               zero_q;
  logic               zero_err_q;
`endif

  logic [SumW-1:0]    sum;
  logic [NSqrt+2:0]   sq_rem_sh, sq_trial;
  logic               sq_bit;
  logic [NSqrt:0]     sq_rem_d;
  logic [NSqrt-1:0]   sq_root_d;
  logic [WIDTH-1:0]   comp, comp_abs;
  logic [NDiv-1:0]    div_dividend, div_quotient;
  logic               div_start, div_busy, div_done;

  // Saturate a quotient to 1.0 and reapply the component sign.
  function automatic logic [WIDTH-1:0] clamp_sign(input logic [NDiv-1:0] q, input logic neg);
    logic [WIDTH-1:0] mag;
    mag = (q > NDiv'(One)) ? One : q[WIDTH-1:0];
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  always_comb begin
    sum = SumW'(rds_q.sqr_x) + SumW'(rds_q.sqr_y) + SumW'(rds_q.sqr_z);

    // Restoring square root: bring down two radicand bits, try (4*root + 1).
    sq_rem_sh = {sq_rem_q, sq_rad_q[RadW-1 -: 2]};
    sq_trial  = {1'b0, sq_root_q, 2'b01};
    sq_bit    = (sq_rem_sh >= sq_trial);
    sq_rem_d  = sq_bit ? (sq_rem_sh[NSqrt:0] - sq_trial[NSqrt:0]) : sq_rem_sh[NSqrt:0];
    sq_root_d = {sq_root_q[NSqrt-2:0], sq_bit};

    case (state_q)
      StDivY:  comp = rds_q.y;
      StDivZ:  comp = rds_q.z;
      default: comp = rds_q.x;
    endcase
    comp_abs     = comp[WIDTH-1] ? (~comp + WIDTH'(1)) : comp;
    div_dividend = {comp_abs, {Q_BITS{1'b0}}};
    div_start    = ((state_q == StDivX) || (state_q == StDivY) || (state_q == StDivZ)) &&
                   (cnt_q == '0) && !div_busy;
  end

  fx_seq_divider #(
    .DividendW (NDiv),
    .DivisorW  (NSqrt)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (sq_root_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rds_q     <= '0;
      sq_rad_q  <= '0;
      sq_rem_q  <= '0;
      sq_root_q <= '0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      RD_out    <= '0;
      overrun   <= 1'b0;
`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
      zero_q     <= 1'b0;
      zero_err_q <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
      overrun   <= start & ~ready;
`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
      zero_err_q <= 1'b0;
`endif
      // The divider's done pulse lands in the first cycle of the next state.
      if (div_done && (state_q == StDivY)) res_x_q <= clamp_sign(div_quotient, rds_q.x[WIDTH-1]);
      if (div_done && (state_q == StDivZ)) res_y_q <= clamp_sign(div_quotient, rds_q.y[WIDTH-1]);

      unique case (state_q)
        StIdle: begin
          if (start) begin
            rds_q   <= RDS_in;
            ready   <= 1'b0;
            state_q <= StSum;
          end
        end
        StSum: begin
          sq_rad_q  <= RadW'({sum, {Q_BITS{1'b0}}});
          sq_rem_q  <= '0;
          sq_root_q <= '0;
          cnt_q     <= '0;
          state_q   <= StSqrt;
`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
          zero_q <= (sum == '0);
          if (sum == '0) state_q <= StDone;
`endif
        end
        StSqrt: begin
          sq_rad_q  <= {sq_rad_q[RadW-3:0], 2'b00};
          sq_rem_q  <= sq_rem_d;
          sq_root_q <= sq_root_d;
          if (cnt_q == CntW'(NSqrt - 1)) begin
            cnt_q   <= '0;
            state_q <= StDivX;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDivX, StDivY, StDivZ: begin
          if (cnt_q == CntW'(NDiv - 1)) begin
            cnt_q   <= '0;
            state_q <= (state_q == StDivX) ? StDivY :
                       (state_q == StDivY) ? StDivZ : StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          RD_out.x  <= res_x_q;
          RD_out.y  <= res_y_q;
          RD_out.z  <= clamp_sign(div_quotient, rds_q.z[WIDTH-1]);
          valid_out <= 1'b1;
          ready     <= 1'b1;
          state_q   <= StIdle;
`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
          if (zero_q) begin
            RD_out     <= '0;
            zero_err_q <= 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DIRECTION_NORMALIZE_ZERO_CHECK_EN
  assign zero_err = zero_err_q;
`else
  assign zero_err = 1'b0;
`endif

endmodule
